// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder: RV32I decode stage feeding the ALU (S/A/B) one stage later.
// Combinational decode of the incoming word lands in a 2-entry skid FIFO; the
// head entry drives the output bundle.
// Optional macro ILLEGAL_TRAP_EN: adds illegal / illegal_seen outputs and passes
// illegal words through with their flags cleared. Without it, illegal words
// are turned into a NOP (ADD rs1+imm with imm=0, rd=0, all flags clear).
module alu_ctrl_decoder #(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2   // only 2 is supported
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      alu_s,
    output logic [1:0]      a_sel,
    output logic            b_sel,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            is_branch,
    output logic            is_jump,
`ifdef ILLEGAL_TRAP_EN
    output logic            illegal,
    output logic            illegal_seen,
`endif
    output logic [XLEN-1:0] pc_out
);

    localparam logic [1:0] DEPTH  = 2'(SKID_DEPTH);
    localparam logic [5:0] ALU_ADD = 6'b000001;

    typedef struct packed {
        logic [5:0]      alu_s;
        logic [1:0]      a_sel;
        logic            b_sel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            is_branch;
        logic            is_jump;
`ifdef ILLEGAL_TRAP_EN
        logic            illegal;
`endif
        logic [XLEN-1:0] pc;
    } bundle_t;

    bundle_t    dec;
    bundle_t    mem_q [2];
    logic       wr_q, wr_d, rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       push, pop, ill;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    // Decode the incoming word into an ALU/control bundle
    always_comb begin
        dec         = '0;
        ill         = 1'b0;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.alu_s   = ALU_ADD;
        case (opc)
            7'b0110011: begin // R-type
                dec.alu_s     = {instr[30], f3, 2'b01};
                dec.reg_write = 1'b1;
                ill = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            7'b0010011: begin // I-type ALU; only SRAI may carry bit 30
                dec.alu_s     = {(f3 == 3'b101) ? instr[30] : 1'b0, f3, 2'b01};
                dec.b_sel     = 1'b1;
                dec.reg_write = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.imm = XLEN'({27'b0, instr[24:20]});
                    ill     = !(f7 == 7'b0000000 || f7 == 7'b0100000);
                end else begin
                    dec.imm = XLEN'($signed({{20{instr[31]}}, instr[31:20]}));
                end
            end
            7'b0000011: begin // LOAD
                dec.b_sel     = 1'b1;
                dec.imm       = XLEN'($signed({{20{instr[31]}}, instr[31:20]}));
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            7'b0100011: begin // STORE
                dec.b_sel     = 1'b1;
                dec.imm       = XLEN'($signed({{20{instr[31]}}, instr[31:25], instr[11:7]}));
                dec.mem_write = 1'b1;
            end
            7'b1100111: begin // JALR
                dec.b_sel     = 1'b1;
                dec.imm       = XLEN'($signed({{20{instr[31]}}, instr[31:20]}));
                dec.is_jump   = 1'b1;
                dec.reg_write = 1'b1;
            end
            7'b1101111: begin // JAL
                dec.a_sel     = 2'd1;
                dec.b_sel     = 1'b1;
                dec.imm       = XLEN'($signed({{12{instr[31]}}, instr[19:12], instr[20],
                                               instr[30:21], 1'b0}));
                dec.is_jump   = 1'b1;
                dec.reg_write = 1'b1;
            end
            7'b0010111: begin // AUIPC
                dec.a_sel     = 2'd1;
                dec.b_sel     = 1'b1;
                dec.imm       = XLEN'($signed({instr[31:12], 12'b0}));
                dec.reg_write = 1'b1;
            end
            7'b0110111: begin // LUI: zero + imm
                dec.a_sel     = 2'd2;
                dec.b_sel     = 1'b1;
                dec.imm       = XLEN'($signed({instr[31:12], 12'b0}));
                dec.reg_write = 1'b1;
            end
            7'b1100011: begin // Branch compare
                dec.alu_s     = {1'b0, f3, 2'b11};
                dec.imm       = XLEN'($signed({{20{instr[31]}}, instr[7], instr[30:25],
                                               instr[11:8], 1'b0}));
                dec.is_branch = 1'b1;
                ill = (f3 == 3'b010 || f3 == 3'b011);
            end
            default: ill = 1'b1;
        endcase
`ifdef ILLEGAL_TRAP_EN
        if (ill) begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
        end
`else
        if (ill) begin
            dec       = '0;
            dec.alu_s = ALU_ADD;
            dec.b_sel = 1'b1;
        end
`endif
        dec.pc = pc;
    end

    assign in_ready  = !rst && (cnt_q != DEPTH);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Skid FIFO pointer/occupancy next state
    always_comb begin
        wr_d  = push ? ~wr_q : wr_q;
        rd_d  = pop  ? ~rd_q : rd_q;
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (!push && pop) cnt_d = cnt_q - 2'd1;
    end

    // FIFO storage and pointers; reset flushes everything to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) mem_q[wr_q] <= dec;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic seen_q;
    // Sticky flag: set once any illegal bundle is pushed
    always_ff @(posedge clk) begin
        if (rst)                      seen_q <= 1'b0;
        else if (push && dec.illegal) seen_q <= 1'b1;
    end
    assign illegal      = mem_q[rd_q].illegal;
    assign illegal_seen = seen_q;
`endif

    assign alu_s     = mem_q[rd_q].alu_s;
    assign a_sel     = mem_q[rd_q].a_sel;
    assign b_sel     = mem_q[rd_q].b_sel;
    assign imm       = mem_q[rd_q].imm;
    assign rd        = mem_q[rd_q].rd;
    assign rs1       = mem_q[rd_q].rs1;
    assign rs2       = mem_q[rd_q].rs2;
    assign reg_write = mem_q[rd_q].reg_write;
    assign mem_read  = mem_q[rd_q].mem_read;
    assign mem_write = mem_q[rd_q].mem_write;
    assign is_branch = mem_q[rd_q].is_branch;
    assign is_jump   = mem_q[rd_q].is_jump;
    assign pc_out    = mem_q[rd_q].pc;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Directed bench for alu_ctrl_decoder; follows ILLEGAL_TRAP_EN like the RTL.
module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, imm, pc_out;
    logic [5:0]  alu_s;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [4:0]  rd, rs1, rs2;
    logic        reg_write, mem_read, mem_write, is_branch, is_jump;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal, illegal_seen;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_ctrl_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .alu_s(alu_s), .a_sel(a_sel), .b_sel(b_sel), .imm(imm),
        .rd(rd), .rs1(rs1), .rs2(rs2), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .is_branch(is_branch),
        .is_jump(is_jump),
`ifdef ILLEGAL_TRAP_EN
        .illegal(illegal), .illegal_seen(illegal_seen),
`endif
        .pc_out(pc_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word, wait (bounded) for in_ready, transfer on the next edge
    task automatic send(input logic [31:0] w, input logic [31:0] p);
        int n = 0;
        instr = w; pc = p; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] s_w [4] = '{32'h002081B3, 32'h402081B3, 32'h40335293, 32'h00209463};
    logic [5:0]  s_a [4] = '{6'b000001, 6'b100001, 6'b110101, 6'b000111};

    initial begin
        int sent, got, gaps, n;
        logic acc;
        rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b0;
        #1 chk("rst_in_ready_during", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_s", 32'(alu_s), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        rst = 1'b0; #1;
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        send(32'h002081B3, 32'h1000);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_alu", 32'(alu_s), 32'h01);
        chk("add_rd", 32'(rd), 32'd3);
        chk("add_rw", 32'(reg_write), 32'd1);
        chk("add_bsel", 32'(b_sel), 32'd0);
        chk("add_pc", pc_out, 32'h1000);
        send(32'h402081B3, 32'h1004);
        chk("sub_alu", 32'(alu_s), 32'h21);
        chk("sub_rd", 32'(rd), 32'd3);
        chk("sub_rw", 32'(reg_write), 32'd1);
        send(32'h40335293, 32'h1008);
        chk("srai_alu", 32'(alu_s), 32'h35);
        chk("srai_imm", imm, 32'd3);
        chk("srai_bsel", 32'(b_sel), 32'd1);
        send(32'h40000093, 32'h100C);
        chk("addi_alu", 32'(alu_s), 32'h01);
        chk("addi_imm", imm, 32'h400);
        send(32'h00209463, 32'h2000);
        chk("bne_alu", 32'(alu_s), 32'h07);
        chk("bne_br", 32'(is_branch), 32'd1);
        chk("bne_imm", imm, 32'd8);
        chk("bne_rw", 32'(reg_write), 32'd0);
        send(32'h123450B7, 32'h2004);
        chk("lui_asel", 32'(a_sel), 32'd2);
        chk("lui_imm", imm, 32'h12345000);
        send(32'h008000EF, 32'h3000);
        chk("jal_asel", 32'(a_sel), 32'd1);
        chk("jal_imm", imm, 32'd8);
        chk("jal_jump", 32'(is_jump), 32'd1);
        chk("jal_rw", 32'(reg_write), 32'd1);
        send(32'h0020A223, 32'h3004);
        chk("sw_mw", 32'(mem_write), 32'd1);
        chk("sw_imm", imm, 32'd4);
        chk("sw_rw", 32'(reg_write), 32'd0);
        @(posedge clk); #1;
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: 4 words offered, only 2 fit while out_ready is low
        out_ready = 1'b0; sent = 0;
        instr = s_w[0]; pc = 32'h100; in_valid = 1'b1;
        repeat (4) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 4) begin instr = s_w[sent]; pc = 32'h100 + 32'(4 * sent); end
                else in_valid = 1'b0;
            end
        end
        chk("bp_accepted", 32'(sent), 32'd2);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_head_stable", pc_out, 32'h100);
        out_ready = 1'b1; got = 0; gaps = 0; n = 0;
        while (got < 4 && n < 20) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("bp_order_alu", 32'(alu_s), 32'(s_a[got]));
                chk("bp_order_pc", pc_out, 32'h100 + 32'(4 * got));
                got++;
            end else if (got > 0) gaps++;
            @(posedge clk); #1; n++;
            if (acc) begin
                sent++;
                if (sent < 4) begin instr = s_w[sent]; pc = 32'h100 + 32'(4 * sent); end
                else in_valid = 1'b0;
            end
        end
        chk("bp_all_out", 32'(got), 32'd4);
        chk("bp_no_gaps", 32'(gaps), 32'd0);

        // Reset with two entries buffered
        out_ready = 1'b0;
        send(32'h002081B3, 32'h4000);
        send(32'h402081B3, 32'h4004);
        chk("rst2_full", 32'(in_ready), 32'd0);
        rst = 1'b1; #1;
        chk("rst2_in_ready_during", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_alu", 32'(alu_s), 32'd0);
        chk("rst2_pc", pc_out, 32'd0);
        rst = 1'b0; #1;
        chk("rst2_in_ready_after", 32'(in_ready), 32'd1);

        // Illegal encodings
        out_ready = 1'b1;
        send(32'h0000007F, 32'h5000);
        chk("ill_rw", 32'(reg_write), 32'd0);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_flag", 32'(illegal), 32'd1);
        @(posedge clk); #1;
        chk("ill_seen", 32'(illegal_seen), 32'd1);
        send(32'h0020A463, 32'h5004);
        chk("ill_br_flag", 32'(illegal), 32'd1);
        chk("ill_br_isbr", 32'(is_branch), 32'd0);
        send(32'h002081B3, 32'h5008);
        chk("ill_legal_after", 32'(illegal), 32'd0);
        chk("ill_seen_sticky", 32'(illegal_seen), 32'd1);
`else
        chk("nop_alu", 32'(alu_s), 32'h01);
        chk("nop_bsel", 32'(b_sel), 32'd1);
        chk("nop_imm", imm, 32'd0);
        chk("nop_rd", 32'(rd), 32'd0);
        send(32'h022081B3, 32'h5004);
        chk("nop_mul_rd", 32'(rd), 32'd0);
        chk("nop_mul_rw", 32'(reg_write), 32'd0);
        send(32'h0020A463, 32'h5008);
        chk("nop_br_isbr", 32'(is_branch), 32'd0);
        chk("nop_br_alu", 32'(alu_s), 32'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_decoder.md
Name: alu_ctrl_decoder

Overview:
Pipelined RV32I decode stage that produces the 6-bit ALU operation code, operand selects and immediate consumed by the ALU (S/A/B inputs) one stage later.
Accepts instruction words over a valid/ready handshake and emits registered decode bundles over a second valid/ready handshake.
Includes a 2-entry skid buffer, so full throughput (1 instr/cycle) is sustained under backpressure.
Sits between instruction fetch and the execute stage.

Parameters:
XLEN, 32, datapath width of instruction, PC and immediate.
SKID_DEPTH, 2, output buffer entries; only 2 is supported.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  instr/pc valid
in_ready  output  1  decoder can accept this cycle
instr  input  32  RV32I instruction word
pc  input  32  instruction address
out_valid  output  1  decode bundle valid
out_ready  input  1  execute stage accepts bundle
alu_s  output  6  ALU operation code
a_sel  output  2  0=rs1, 1=pc, 2=zero
b_sel  output  1  0=rs2, 1=imm
imm  output  32  sign-extended immediate
rd, rs1, rs2  output  5 each  register indices
reg_write, mem_read, mem_write, is_branch, is_jump  output  1 each  control flags
pc_out  output  32  pc carried with bundle

Behaviour:
- Transfer on each side occurs when valid && ready are high at the same rising edge.
- Decode is combinational from instr. The result enters the skid buffer (FIFO, 2 entries) on an input transfer. Latency is 1 cycle: an instr accepted at edge N is presented with out_valid=1 after edge N.
- in_ready = (entries < 2), derived from registered occupancy.
- Simultaneous push and pop keeps occupancy unchanged and preserves order.
- out_valid = (entries > 0). Output fields come from the head entry and stay stable while out_valid && !out_ready.
- Reset: entries=0, out_valid=0, in_ready=0 during the rst cycle and 1 after it. All output fields are 0. Reset mid-stream discards buffered entries.
- alu_s encoding:
  - R-type (0110011): {instr[30], funct3, 2'b01}. ADD=000001, SUB=100001, SLL=000101, SLT=001001, SLTU=001101, XOR=010001, SRL=010101, SRA=110101, OR=011001, AND=011101.
  - I-type ALU (0010011): {instr[30] only when funct3=101, else 0, funct3, 2'b01}. ADDI never maps to SUB.
  - Branch (1100011): {1'b0, funct3, 2'b11}. BEQ=000011, BNE=000111, BLT=010011, BGE=010111, BLTU=011011, BGEU=011111. is_branch=1, b_sel=0.
  - LOAD, STORE, JALR: ADD with a_sel=rs1, b_sel=imm.
  - JAL and AUIPC: ADD with a_sel=pc.
  - LUI: ADD with a_sel=zero, b_sel=imm.
  - JAL/JALR set is_jump=1 and reg_write=1.
- Immediates are standard RV32I I/S/B/U/J formats, sign-extended to 32 bits. B and J immediates have bit 0 = 0.
- Illegal instruction conditions:
  - Unknown opcode.
  - funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101}, for R-type.
  - Shift-immediate with instr[31:25] not in {0000000, 0100000}.
  - Branch funct3 of 010 or 011.
- Writes to rd=0 keep reg_write=1; the register file ignores them.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: adds ports illegal (output 1, per-bundle) and illegal_seen (output 1, sticky, cleared only by rst). An illegal instr is passed through with illegal=1 and all of reg_write, mem_read, mem_write, is_branch, is_jump forced to 0. illegal_seen rises the cycle after that bundle is pushed.
- Undefined: those ports are absent. Illegal instrs are emitted as NOP (alu_s=000001, a_sel=rs1, b_sel=imm, imm=0, rd=0, all flags 0).

Test Plan:
- Send 0x002081B3 (add x3,x1,x2), then 0x402081B3 (sub) -> alu_s=000001 then 100001. Both have rd=3, reg_write=1, b_sel=0, and appear 1 cycle after acceptance.
- Send 0x40335293 (srai x5,x6,3) -> alu_s=110101, imm=3, b_sel=1. Send 0x40000093 (addi x1,x0,1024) -> alu_s=000001 (not 100001), imm=0x400.
- Send 0x00209463 (bne x1,x2,+8) -> alu_s=000111, is_branch=1, imm=8, reg_write=0.
- Stream 4 instrs back-to-back with out_ready=0 -> exactly 2 accepted, in_ready=0 while full. Release out_ready=1 -> all 4 emerge in order, with no gaps once steady.
- Assert rst with 2 entries buffered -> out_valid=0 the next cycle and outputs zero. in_ready is 0 during the rst cycle and 1 after it.
- Send 0x0000007F -> with ILLEGAL_TRAP_EN: illegal=1, flags 0, illegal_seen=1 until rst. Without the macro: NOP bundle, alu_s=000001.
